// File: rtl/mac_accumulator.sv
// Saturating dot-product accumulator: sums len unsigned 16-bit products into
// an ACC_W-bit register, then drains the result MSB-first as a byte stream.
module mac_accumulator #(
  parameter int ACC_W = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [7:0]  len,
  input  logic        prod_valid,
  input  logic [15:0] prod_data,
  output logic        prod_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        out_last,
  input  logic        out_ready,
  output logic        sat
);

  localparam int NB = (ACC_W + 7) / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [1:0] K_LAST = 2'(NB - 1);

  // Handshakes: a product moves on a rising edge with prod_valid & prod_ready,
  // a result byte moves on a rising edge with out_valid & out_ready; valid
  // never depends on ready and neither side may retract data once offered.

  logic [1:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [8:0]        cnt;
  logic [8:0]        tgt;
  logic [1:0]        k;
  logic [ACC_W:0]    sum;
  logic [8:0]        len_eff;
  logic [NB*8-1:0]   result;
  logic              accept;
  logic              out_hs;

  assign prod_ready = (state != S_DRAIN) && !clr;
  assign accept     = prod_valid && prod_ready;
  assign out_valid  = (state == S_DRAIN);
  assign out_hs     = out_valid && out_ready;
  assign out_last   = out_valid && (k == K_LAST);
  assign len_eff    = (len == 8'd0) ? 9'd256 : {1'b0, len};

  // One extra bit of headroom so the clamp can see the carry instead of a wrap.
  assign sum = {1'b0, acc} + (ACC_W + 1)'(prod_data);

  always_comb begin
    result = '0;
    result[ACC_W-1:0] = acc;
  end

  always_comb begin
    out_byte = '0;
    if (state == S_DRAIN) begin
      for (int i = 0; i < NB; i++) begin
        if (k == 2'(NB - 1 - i)) out_byte = result[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      tgt   <= '0;
      k     <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      k     <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            acc   <= ACC_W'(prod_data);
            cnt   <= 9'd1;
            tgt   <= len_eff;
            sat   <= 1'b0;
            state <= (len_eff == 9'd1) ? S_DRAIN : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            if (sum[ACC_W]) begin
              acc <= '1;
              sat <= 1'b1;
            end else begin
              acc <= sum[ACC_W-1:0];
            end
            cnt <= cnt + 9'd1;
            if (cnt + 9'd1 == tgt) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_hs) begin
            if (k == K_LAST) begin
              state <= S_IDLE;
              acc   <= '0;
              cnt   <= '0;
              k     <= '0;
              sat   <= 1'b0;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
